// File: rtl/bus_timer.sv
// Memory-mapped 64-bit timer (mtime/mtimecmp/ctrl) on a single-cycle-response device port.
// Optional BUS_TIMER_PRESCALER_EN adds a 16-bit prescale register at 0x14 dividing the tick rate.
module bus_timer #(
   parameter int unsigned AddressWidth = 32,
   parameter int unsigned DataWidth    = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    device_req_i,
   input  logic [AddressWidth-1:0] device_addr_i,
   input  logic                    device_we_i,
   input  logic [DataWidth/8-1:0]  device_be_i,
   input  logic [DataWidth-1:0]    device_wdata_i,
   output logic                    device_rvalid_o,
   output logic [DataWidth-1:0]    device_rdata_o,
   output logic                    device_err_o,
   output logic                    timer_irq_o
);

   if (DataWidth != 32) begin : g_bad_width
      $error("bus_timer supports DataWidth = 32 only");
   end

   localparam logic [2:0] ADDR_MTIME_LO    = 3'd0;
   localparam logic [2:0] ADDR_MTIME_HI    = 3'd1;
   localparam logic [2:0] ADDR_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] ADDR_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] ADDR_CTRL        = 3'd4;
   localparam logic [2:0] ADDR_PRESCALE    = 3'd5;

   function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
      end
      return res;
   endfunction

   logic [63:0] mtime_q, mtime_d, mtime_inc;
   logic [31:0] hi_shadow_q, hi_shadow_d;
   logic [63:0] cmp_q, cmp_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        rvalid_q, rvalid_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] rd_val;
   logic        tick, wr, rd, mapped;
   logic [2:0]  reg_sel;
   logic        unused_addr;

`ifdef BUS_TIMER_PRESCALER_EN
   logic [15:0] prescale_q, prescale_d;
   logic [15:0] pre_cnt_q, pre_cnt_d;
`endif

   assign reg_sel     = device_addr_i[4:2];
   assign unused_addr = ^{device_addr_i[AddressWidth-1:5], device_addr_i[1:0]};
   assign wr          = device_req_i & device_we_i;
   assign rd          = device_req_i & ~device_we_i;

   always_comb begin
`ifdef BUS_TIMER_PRESCALER_EN
      tick       = ctrl_q[0] & (pre_cnt_q == prescale_q);
      pre_cnt_d  = ctrl_q[0] ? (tick ? 16'd0 : pre_cnt_q + 16'd1) : pre_cnt_q;
      prescale_d = prescale_q;
`else
      tick       = ctrl_q[0];
`endif
      mtime_inc   = mtime_q + 64'd1;
      // Unwritten bytes of a written mtime word still take the ticked value.
      mtime_d     = tick ? mtime_inc : mtime_q;
      hi_shadow_d = hi_shadow_q;
      cmp_d       = cmp_q;
      ctrl_d      = ctrl_q;
      mapped      = 1'b1;
      rd_val      = 32'd0;
      case (reg_sel)
         ADDR_MTIME_LO: begin
            rd_val = mtime_q[31:0];
            if (wr) mtime_d[31:0] = merge_be(mtime_d[31:0], device_wdata_i, device_be_i);
            if (rd) hi_shadow_d = mtime_q[63:32];
         end
         ADDR_MTIME_HI: begin
            rd_val = hi_shadow_q;
            if (wr) mtime_d[63:32] = merge_be(mtime_d[63:32], device_wdata_i, device_be_i);
         end
         ADDR_MTIMECMP_LO: begin
            rd_val = cmp_q[31:0];
            if (wr) cmp_d[31:0] = merge_be(cmp_q[31:0], device_wdata_i, device_be_i);
         end
         ADDR_MTIMECMP_HI: begin
            rd_val = cmp_q[63:32];
            if (wr) cmp_d[63:32] = merge_be(cmp_q[63:32], device_wdata_i, device_be_i);
         end
         ADDR_CTRL: begin
            rd_val = {30'd0, ctrl_q};
            if (wr && device_be_i[0]) ctrl_d = device_wdata_i[1:0];
`ifdef BUS_TIMER_PRESCALER_EN
            if (wr) pre_cnt_d = 16'd0;
`endif
         end
`ifdef BUS_TIMER_PRESCALER_EN
         ADDR_PRESCALE: begin
            rd_val = {16'd0, prescale_q};
            if (wr) begin
               if (device_be_i[0]) prescale_d[7:0]  = device_wdata_i[7:0];
               if (device_be_i[1]) prescale_d[15:8] = device_wdata_i[15:8];
               pre_cnt_d = 16'd0;
            end
         end
`endif
         default: mapped = 1'b0;
      endcase
      rvalid_d = device_req_i;
      err_d    = device_req_i & ~mapped;
      rdata_d  = (rd && mapped) ? rd_val : 32'd0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mtime_q     <= 64'd0;
         hi_shadow_q <= 32'd0;
         cmp_q       <= '1;
         ctrl_q      <= 2'd0;
         rvalid_q    <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= 32'd0;
      end else begin
         mtime_q     <= mtime_d;
         hi_shadow_q <= hi_shadow_d;
         cmp_q       <= cmp_d;
         ctrl_q      <= ctrl_d;
         rvalid_q    <= rvalid_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
      end
   end

`ifdef BUS_TIMER_PRESCALER_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prescale_q <= 16'd0;
         pre_cnt_q  <= 16'd0;
      end else begin
         prescale_q <= prescale_d;
         pre_cnt_q  <= pre_cnt_d;
      end
   end
`endif

   assign device_rvalid_o = rvalid_q;
   assign device_err_o    = err_q;
   assign device_rdata_o  = rdata_q;
   // Registered-only compare keeps bus inputs off the interrupt path.
   assign timer_irq_o     = ctrl_q[1] & (mtime_q >= cmp_q);

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: register-access vector table plus hand-built
// sequences for snapshot, tick/write merge, wrap, reset, interrupt and prescaler.
module tb_bus_timer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;
   logic        irq;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [3:0]  b;
      logic [31:0] d;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [20];

   bus_timer #(.AddressWidth(32), .DataWidth(32)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .device_req_i   (req),
      .device_addr_i  (addr),
      .device_we_i    (we),
      .device_be_i    (be),
      .device_wdata_i (wdata),
      .device_rvalid_o(rvalid),
      .device_rdata_o (rdata),
      .device_err_o   (err),
      .timer_irq_o    (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d);
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
   endtask

   task automatic idle();
      req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
   endtask

   // One request, then leaves the bench at the negedge where its response is visible.
   task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
      @(negedge clk);
      drive(w, a, b, d);
      @(negedge clk);
      idle();
   endtask

   task automatic resp(input string name, input logic [31:0] exp_rdata, input logic exp_err);
      chk({name, "_rvalid"}, rvalid, 1'b1);
      chk({name, "_rdata"}, rdata, exp_rdata);
      chk({name, "_err"}, err, exp_err);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 32'h08, 4'hF, 32'h0,         32'hFFFF_FFFF, 1'b0};
      vecs[1]  = '{1'b0, 32'h0C, 4'hF, 32'h0,         32'hFFFF_FFFF, 1'b0};
      vecs[2]  = '{1'b0, 32'h10, 4'hF, 32'h0,         32'h0,         1'b0};
      vecs[3]  = '{1'b0, 32'h00, 4'hF, 32'h0,         32'h0,         1'b0};
      vecs[4]  = '{1'b0, 32'h04, 4'hF, 32'h0,         32'h0,         1'b0};
      vecs[5]  = '{1'b1, 32'h08, 4'h5, 32'hAABB_CCDD, 32'h0,         1'b0};
      vecs[6]  = '{1'b0, 32'h08, 4'hF, 32'h0,         32'hFFBB_FFDD, 1'b0};
      vecs[7]  = '{1'b1, 32'h18, 4'hF, 32'h1234_5678, 32'h0,         1'b1};
      vecs[8]  = '{1'b0, 32'h18, 4'hF, 32'h0,         32'h0,         1'b1};
      vecs[9]  = '{1'b1, 32'h1C, 4'hF, 32'h1234_5678, 32'h0,         1'b1};
      vecs[10] = '{1'b0, 32'h1C, 4'hF, 32'h0,         32'h0,         1'b1};
      vecs[11] = '{1'b0, 32'h08, 4'hF, 32'h0,         32'hFFBB_FFDD, 1'b0};
      vecs[12] = '{1'b1, 32'h0C, 4'h0, 32'h0,         32'h0,         1'b0};
      vecs[13] = '{1'b0, 32'h0C, 4'hF, 32'h0,         32'hFFFF_FFFF, 1'b0};
`ifdef BUS_TIMER_PRESCALER_EN
      vecs[14] = '{1'b0, 32'h14, 4'hF, 32'h0,         32'h0,         1'b0};
`else
      vecs[14] = '{1'b0, 32'h14, 4'hF, 32'h0,         32'h0,         1'b1};
`endif
      vecs[15] = '{1'b1, 32'h10, 4'hF, 32'h0000_0002, 32'h0,         1'b0};
      vecs[16] = '{1'b0, 32'h10, 4'hF, 32'h0,         32'h2,         1'b0};
      vecs[17] = '{1'b1, 32'h10, 4'hF, 32'h0,         32'h0,         1'b0};
      vecs[18] = '{1'b0, 32'h00, 4'hF, 32'h0,         32'h0,         1'b0};
      vecs[19] = '{1'b0, 32'h10, 4'hF, 32'h0,         32'h0,         1'b0};

      repeat (3) @(negedge clk);
      chk("reset_rvalid", rvalid, 1'b0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_err", err, 1'b0);
      chk("reset_irq", irq, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         access(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].d);
         resp($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_err);
         chk($sformatf("vec%0d_irq", i), irq, 1'b0);
      end
      @(negedge clk);
      chk("idle_rvalid", rvalid, 1'b0);
      chk("idle_rdata", rdata, 32'h0);

      // Tear-free snapshot with back-to-back requests across the low-word carry.
      access(1'b1, 32'h00, 4'hF, 32'hFFFF_FFFE);
      access(1'b1, 32'h10, 4'hF, 32'h1);
      @(negedge clk);
      drive(1'b0, 32'h00, 4'hF, 32'h0);
      @(negedge clk);
      resp("snap_lo0", 32'hFFFF_FFFF, 1'b0);
      drive(1'b0, 32'h04, 4'hF, 32'h0);
      @(negedge clk);
      resp("snap_hi0", 32'h0, 1'b0);
      drive(1'b0, 32'h00, 4'hF, 32'h0);
      @(negedge clk);
      resp("snap_lo1", 32'h1, 1'b0);
      drive(1'b0, 32'h04, 4'hF, 32'h0);
      @(negedge clk);
      resp("snap_hi1", 32'h1, 1'b0);
      idle();
      @(negedge clk);
      chk("snap_idle_rvalid", rvalid, 1'b0);

      // Byte write to mtime_lo in a tick cycle: unwritten bytes take the incremented value.
      access(1'b1, 32'h10, 4'hF, 32'h0);
      access(1'b1, 32'h04, 4'hF, 32'h0);
      access(1'b1, 32'h00, 4'hF, 32'h0000_01FF);
      access(1'b1, 32'h10, 4'hF, 32'h1);
      access(1'b1, 32'h00, 4'b0010, 32'h0000_7700);
      access(1'b0, 32'h00, 4'hF, 32'h0);
      resp("merge_lo", 32'h0000_7702, 1'b0);
      access(1'b0, 32'h04, 4'hF, 32'h0);
      resp("merge_hi", 32'h0, 1'b0);

      // 64-bit wrap.
      access(1'b1, 32'h10, 4'hF, 32'h0);
      access(1'b1, 32'h00, 4'hF, 32'hFFFF_FFFF);
      access(1'b1, 32'h04, 4'hF, 32'hFFFF_FFFF);
      access(1'b1, 32'h10, 4'hF, 32'h1);
      access(1'b0, 32'h00, 4'hF, 32'h0);
      resp("wrap_lo", 32'h0, 1'b0);
      access(1'b0, 32'h04, 4'hF, 32'h0);
      resp("wrap_hi", 32'h0, 1'b0);

      // Reset with a response in flight drops it and clears all state.
      @(negedge clk);
      drive(1'b0, 32'h08, 4'hF, 32'h0);
      @(posedge clk);
      #1;
      chk("rst_pending_rvalid", rvalid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_drop_rvalid", rvalid, 1'b0);
      chk("rst_drop_rdata", rdata, 32'h0);
      idle();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_after_rvalid", rvalid, 1'b0);
      access(1'b0, 32'h00, 4'hF, 32'h0);
      resp("rst_mtime_lo", 32'h0, 1'b0);
      access(1'b0, 32'h10, 4'hF, 32'h0);
      resp("rst_ctrl", 32'h0, 1'b0);
      access(1'b0, 32'h08, 4'hF, 32'h0);
      resp("rst_cmp_lo", 32'hFFFF_FFFF, 1'b0);

      // Interrupt rises when mtime reaches mtimecmp, cleared by software.
      access(1'b1, 32'h0C, 4'hF, 32'h0);
      access(1'b1, 32'h08, 4'hF, 32'd10);
      chk("irq_before_en", irq, 1'b0);
      access(1'b1, 32'h10, 4'hF, 32'h3);
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("irq_mtime%0d", k), irq, (k >= 10));
         @(negedge clk);
      end
      access(1'b1, 32'h0C, 4'hF, 32'h1);
      chk("irq_cmp_hi_clear", irq, 1'b0);
      access(1'b1, 32'h0C, 4'hF, 32'h0);
      chk("irq_cmp_hi_back", irq, 1'b1);
      access(1'b1, 32'h10, 4'hF, 32'h1);
      chk("irq_en_clear", irq, 1'b0);
      access(1'b1, 32'h10, 4'hF, 32'h0);

`ifdef BUS_TIMER_PRESCALER_EN
      access(1'b1, 32'h00, 4'hF, 32'h0);
      access(1'b1, 32'h04, 4'hF, 32'h0);
      access(1'b1, 32'h14, 4'hF, 32'h3);
      resp("pre_write", 32'h0, 1'b0);
      access(1'b0, 32'h14, 4'hF, 32'h0);
      resp("pre_read", 32'h3, 1'b0);
      access(1'b1, 32'h10, 4'hF, 32'h1);
      repeat (7) @(negedge clk);
      access(1'b0, 32'h00, 4'hF, 32'h0);
      resp("pre_mtime", 32'h2, 1'b0);
`else
      access(1'b1, 32'h14, 4'hF, 32'h3);
      resp("nopre_write", 32'h0, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped 64-bit timer device that sits on one device port of the simple Ibex bus and answers every request in the following cycle, as the bus requires. It holds a free-running `mtime` counter, a `mtimecmp` compare register and a control register. It drives a level timer interrupt to the core. Reads of `mtime_lo` snapshot the high word so software sees a tear-free 64-bit value.

## Interface
- `AddressWidth`, default 32: width of `device_addr_i`. Only bits [4:2] are decoded; the bus has already selected this device.
- `DataWidth`, default 32: bus data width. Only 32 is supported; elaboration fails otherwise.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `device_req_i` input 1: request, valid for one cycle.
- `device_addr_i` input AddressWidth: byte address. Bits [1:0] are ignored.
- `device_we_i` input 1: 1 = write, 0 = read.
- `device_be_i` input DataWidth/8: byte enables for writes.
- `device_wdata_i` input DataWidth: write data.
- `device_rvalid_o` output 1: response valid, exactly one cycle after each request.
- `device_rdata_o` output DataWidth: read data. It is 0 for writes and errors.
- `device_err_o` output 1: error response, qualified by `device_rvalid_o`.
- `timer_irq_o` output 1: level interrupt.

## Operation
- Register map, selected by addr[4:2]:
  - 0x00 `mtime_lo`, RW.
  - 0x04 `mtime_hi`: writes go to `mtime[63:32]`; reads return `hi_shadow`.
  - 0x08 `mtimecmp_lo`, RW.
  - 0x0C `mtimecmp_hi`, RW.
  - 0x10 `ctrl`: bit0 `en`, bit1 `irq_en`. Other bits read 0.
  - 0x14 `prescale`: exists only with the macro; see Configuration.
  - Every other offset is unmapped.
- Reading `mtime_lo` returns `mtime[31:0]` and, on the same edge, loads `hi_shadow <= mtime[63:32]`. Both values are sampled in the request cycle.
- Writes update only the bytes whose `device_be_i` bit is set. Writes with `be = 0` are accepted and change nothing.
- An unmapped access returns `rvalid=1`, `err=1`, `rdata=0`. An unmapped write has no effect.
- Counting:
  - When `en=1`, `mtime` increments by 1 on each tick.
  - The 64-bit value wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
  - When `en=0`, `mtime` holds its value.
- Simultaneous bus write to an `mtime` word and a tick: the written bytes take the written value; the unwritten bytes take the incremented value. There is no carry from a written low word into the high word in that cycle.
- `timer_irq_o = irq_en & (mtime >= mtimecmp)`. The comparison is unsigned 64-bit and uses the registered values, so there is no combinational path from bus inputs.
- The interrupt is cleared only by software: writing `mtimecmp` above `mtime`, or clearing `irq_en`.

## Timing
- Request in cycle N gives `rvalid` in cycle N+1. `rdata` and `err` are registered and hold that value only in N+1. They are 0 in every other cycle.
- Back-to-back requests on consecutive cycles are fully supported, giving one response per cycle.
- A write lands at the end of cycle N. A read in cycle N+1 returns the new value. `timer_irq_o` reflects the new `mtimecmp` or `ctrl` in cycle N+1.
- With `en=1` and no prescaler, `mtime` advances by exactly 1 per cycle. A `mtime_lo` read issued in cycle N returns the value held in cycle N.
- Reset values:
  - `mtime`, `hi_shadow` and `ctrl` are 0.
  - `mtimecmp` is all-ones.
  - `device_rvalid_o`, `device_err_o`, `device_rdata_o` and `timer_irq_o` are 0.
- Reset asserted mid-operation clears everything at once. A pending response is dropped, with no `rvalid` after reset deasserts.

## Configuration
- `BUS_TIMER_PRESCALER_EN` defined:
  - Adds a 16-bit `prescale` register at 0x14, RW with byte enables, reset 0.
  - Adds an internal 16-bit `pre_cnt`.
  - With `en=1`: when `pre_cnt == prescale`, a tick occurs and `pre_cnt <= 0`; otherwise `pre_cnt` increments. `mtime` therefore advances once every `prescale+1` cycles.
  - Writing `prescale` or `ctrl` clears `pre_cnt`.
- Not defined: a tick occurs every cycle while `en=1`, and offset 0x14 is unmapped (error response).

## Test plan
- Reset, then read 0x08 and 0x0C → both return 0xFFFF_FFFF in the next cycle with `err=0`; `timer_irq_o=0`.
- Write `mtime_lo=0xFFFF_FFFE` and `ctrl=1`, wait 2 cycles, read `mtime_lo` then `mtime_hi` → the high word read returns 1, the value snapshotted at the low-word read, not a later value.
- Set `mtimecmp=10`, `ctrl=3` from `mtime=0` → `timer_irq_o` rises in the cycle `mtime` reads 10. Writing `mtimecmp_hi=1` drops it the next cycle.
- Write 0xAABBCCDD to `mtimecmp_lo` with `be=4'b0101` after reset → readback is 0xFFBBFFDD.
- Read and write 0x18, then 0x1C → `rvalid=1`, `err=1`, `rdata=0` each cycle; all registers unchanged.
- With `BUS_TIMER_PRESCALER_EN`: `prescale=3`, `ctrl=1` → `mtime` reads 2 after 8 cycles. Without the macro, an access to 0x14 returns `err=1`.
